// File: rtl/car_pkg.sv
// Shared encodings for the car datapath: drive commands decoded by car_control,
// the ASCII command bytes accepted from the phone, and the UART receiver states.
package car_pkg;

  localparam logic [2:0] CMD_ZERO         = 3'd0;
  localparam logic [2:0] CMD_ACC          = 3'd1;
  localparam logic [2:0] CMD_DEC          = 3'd2;
  localparam logic [2:0] CMD_LEFT         = 3'd3;
  localparam logic [2:0] CMD_RIGHT        = 3'd4;
  localparam logic [2:0] CMD_MOVE_FORWARD = 3'd5;
  localparam logic [2:0] CMD_MOVE_BACK    = 3'd6;
  localparam logic [2:0] CMD_STOP         = 3'd7;

  localparam logic [7:0] ASC_F = 8'h46;
  localparam logic [7:0] ASC_B = 8'h42;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  // '0'..'7' share the upper five bits 5'b00110
  function automatic logic is_cmd_digit(input logic [7:0] b);
    return b[7:3] == 5'b00110;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF input sync, mid-bit sampling FSM, LSB-first shifter.
// rx_done / rx_ferr are combinational pulses on the stop-bit sample cycle.
module uart_rx_byte
  import car_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_ferr
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int BW  = $clog2(DIV);
  localparam logic [BW-1:0] HALF_M1 = BW'(DIV / 2 - 1);
  localparam logic [BW-1:0] FULL_M1 = BW'(DIV - 1);

  logic [1:0]    sync_q;
  logic          rx_s;
  rx_state_e     state, nxt;
  logic [BW-1:0] bcnt;
  logic [2:0]    nbit;
  logic [7:0]    shreg;
  logic          tick_half, tick_full;

  // Sync flops reset to the idle-high line level so reset never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];

  assign tick_half = (bcnt == HALF_M1);
  assign tick_full = (bcnt == FULL_M1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RX_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      RX_IDLE:      if (!rx_s) nxt = RX_START;
      RX_START:     if (tick_half) nxt = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:      if (tick_full && nbit == 3'd7) nxt = RX_STOP;
      RX_STOP:      if (tick_full) nxt = rx_s ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rx_s) nxt = RX_IDLE;
      default:      nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_done = 1'b0;
    rx_ferr = 1'b0;
    if (state == RX_STOP && tick_full) begin
      rx_done = rx_s;
      rx_ferr = !rx_s;
    end
  end

  // Bit timer restarts at each sample point; start bit sampled at half a bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt  <= '0;
      nbit  <= '0;
      shreg <= '0;
    end else begin
      case (state)
        RX_START: begin
          bcnt <= tick_half ? '0 : bcnt + BW'(1);
          nbit <= '0;
        end
        RX_DATA: begin
          bcnt <= tick_full ? '0 : bcnt + BW'(1);
          if (tick_full) begin
            nbit  <= nbit + 3'd1;
            shreg <= {rx_s, shreg[7:1]};
          end
        end
        RX_STOP: bcnt <= tick_full ? '0 : bcnt + BW'(1);
        default: bcnt <= '0;
      endcase
    end
  end

  assign rx_data = shreg;

endmodule

// File: rtl/bt_cmd_rx.sv
// Bluetooth command receiver: decodes '0'..'7', 'F', 'B' into cmd/mode for car_control.
// Define BT_CMD_WATCHDOG_EN to build the link watchdog that forces CMD_STOP on silence.
module bt_cmd_rx
  import car_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int WD_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [2:0] cmd,
  output logic       mode,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       wd_trip
);

  logic [7:0] rx_data;
  logic       rx_done, rx_ferr;
  logic       hit_digit, hit_f, hit_b, hit;
  logic       wd_force;

  uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .rx_data (rx_data),
    .rx_done (rx_done),
    .rx_ferr (rx_ferr)
  );

  always_comb begin
    hit_digit = rx_done && is_cmd_digit(rx_data);
    hit_f     = rx_done && (rx_data == ASC_F);
    hit_b     = rx_done && (rx_data == ASC_B);
    hit       = hit_digit || hit_f || hit_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd       <= CMD_ZERO;
      mode      <= 1'b1;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cmd_valid <= hit;
      frame_err <= rx_ferr;
      if (hit_digit)     cmd <= rx_data[2:0];
      else if (wd_force) cmd <= CMD_STOP;
      if (hit_f)         mode <= 1'b1;
      else if (hit_b)    mode <= 1'b0;
    end
  end

`ifdef BT_CMD_WATCHDOG_EN
  localparam int WW = $clog2(WD_CYCLES + 1);

  logic [WW-1:0] wd_cnt;
  logic          wd_exp;

  // A recognised byte landing on the expiry cycle wins over the trip
  assign wd_exp   = (cmd != CMD_STOP) && (wd_cnt == WW'(WD_CYCLES - 1));
  assign wd_force = wd_exp && !hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt  <= '0;
      wd_trip <= 1'b0;
    end else begin
      wd_trip <= wd_force;
      if (hit || wd_exp)
        wd_cnt <= '0;
      else if (cmd != CMD_STOP && wd_cnt != WW'(WD_CYCLES))
        wd_cnt <= wd_cnt + WW'(1);
    end
  end
`else
  assign wd_force = 1'b0;
  assign wd_trip  = 1'b0;
`endif

endmodule
